// File: rtl/result_reader.sv
// rtl/result_reader.sv - result buffer drain engine: RAM reads streamed out over valid/ready
// Optional feature macro: RESULT_READER_ARGMAX_EN (adds argmax_index / argmax_valid)
module result_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] result_base_address,
  input  logic [ADDR_WIDTH-1:0] result_word_count,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
`ifdef RESULT_READER_ARGMAX_EN
  ,
  output logic [ADDR_WIDTH-1:0] argmax_index,
  output logic                  argmax_valid
`endif
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   remaining;

`ifdef RESULT_READER_ARGMAX_EN
  logic [ADDR_WIDTH-1:0]   index_q;
  logic signed [DATA_WIDTH-1:0] max_q;
`endif

  // Drain sequencer: every output is a register updated alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      remaining <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef RESULT_READER_ARGMAX_EN
      index_q      <= '0;
      max_q        <= '0;
      argmax_index <= '0;
      argmax_valid <= 1'b0;
`endif
    end else begin
      // done is a single-cycle pulse unless re-armed below
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q    <= result_base_address;
            remaining <= result_word_count;
            busy      <= 1'b1;
`ifdef RESULT_READER_ARGMAX_EN
            index_q      <= '0;
            argmax_valid <= 1'b0;
`endif
            if (result_word_count == ADDR_ZERO) begin
              // Empty descriptor: skip straight to the completion pulse
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_READ;
              mem_rd_en <= 1'b1;
              mem_addr  <= result_base_address;
            end
          end
        end

        S_READ: begin
          // The strobe was presented this cycle; RAM returns data next cycle
          mem_rd_en <= 1'b0;
          state     <= S_WAIT;
        end

        S_WAIT: begin
          out_data  <= mem_rd_data;
          out_valid <= 1'b1;
          out_last  <= (remaining == ADDR_ONE);
          state     <= S_PRESENT;
        end

        S_PRESENT: begin
          // out_valid is always high here, so a transfer is just out_ready
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            addr_q    <= addr_q + ADDR_ONE;
            remaining <= remaining - ADDR_ONE;
`ifdef RESULT_READER_ARGMAX_EN
            index_q <= index_q + ADDR_ONE;
            // Strict greater-than keeps the lowest index on ties
            if (index_q == ADDR_ZERO || $signed(out_data) > max_q) begin
              max_q        <= $signed(out_data);
              argmax_index <= index_q;
            end
`endif
            if (remaining == ADDR_ONE) begin
              state <= S_DONE;
              done  <= 1'b1;
`ifdef RESULT_READER_ARGMAX_EN
              argmax_valid <= 1'b1;
`endif
            end else begin
              state     <= S_READ;
              mem_rd_en <= 1'b1;
              mem_addr  <= addr_q + ADDR_ONE;
            end
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_reader.sv
// tb/tb_result_reader.sv - scoreboard bench for result_reader
module tb_result_reader;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] result_base_address = '0;
  logic [AW-1:0] result_word_count = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef RESULT_READER_ARGMAX_EN
  logic [AW-1:0] argmax_index;
  logic          argmax_valid;
`endif

  result_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .result_base_address (result_base_address),
    .result_word_count   (result_word_count),
    .mem_rd_en           (mem_rd_en),
    .mem_addr            (mem_addr),
    .mem_rd_data         (mem_rd_data),
    .out_data            (out_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_last            (out_last),
    .busy                (busy),
    .done                (done)
`ifdef RESULT_READER_ARGMAX_EN
    ,
    .argmax_index        (argmax_index),
    .argmax_valid        (argmax_valid)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model
  logic [DW-1:0] ram [256];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

  int tests = 0;
  int fails = 0;

  logic [8:0]    exp_word [$];  // {last, data}
  logic [AW-1:0] exp_addr [$];

  int rd_cnt = 0;
  int valid_cnt = 0;
  int done_cnt = 0;
  int xfer_idx = 0;
  int stall_at = -1;
  int stall_left = 0;

  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b1;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every read strobe and every stream transfer
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (mem_rd_en) begin
        rd_cnt++;
        if (exp_addr.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_read: got addr %0h expected no read", mem_addr);
        end else begin
          check("mem_addr", mem_addr, exp_addr.pop_front());
        end
      end
      if (prev_valid && !prev_ready) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
      end
      if (out_valid) valid_cnt++;
      if (out_valid && out_ready) begin
        if (exp_word.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h expected no word", out_data);
        end else begin
          logic [8:0] w;
          w = exp_word.pop_front();
          check("out_data", out_data, w[7:0]);
          check("out_last", out_last, w[8]);
        end
        xfer_idx++;
      end
      if (done) done_cnt++;
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
    end
  end

  // Ready driver: holds out_ready low for stall_left valid cycles on word stall_at
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && out_valid && xfer_idx == stall_at) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic push_word(input logic [7:0] d, input logic last);
    exp_word.push_back({last, d});
  endtask

  task automatic issue_start(input logic [AW-1:0] base, input logic [AW-1:0] cnt);
    @(posedge clk);
    #1;
    start = 1'b1;
    result_base_address = base;
    result_word_count = cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    result_base_address = 8'h5A;
    result_word_count = 8'h33;
  endtask

  // Starts a drain and checks the completion timing relative to the start edge
  task automatic drain(input logic [AW-1:0] base, input logic [AW-1:0] cnt,
                       input int exp_edges, input logic [AW-1:0] am_idx, input logic am_valid);
    int n;
    issue_start(base, cnt);
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      n++;
    end
    check("done_latency", n, exp_edges);
    check("busy_at_done", busy, 1);
    check("words_left", exp_word.size(), 0);
    check("reads_left", exp_addr.size(), 0);
`ifdef RESULT_READER_ARGMAX_EN
    check("argmax_valid", argmax_valid, am_valid);
    if (am_valid) check("argmax_index", argmax_index, am_idx);
`endif
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    int d0, r0, v0, k, base_x;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
    ram[8'h10] = 8'h05; ram[8'h11] = 8'h7F; ram[8'h12] = 8'h80; ram[8'h13] = 8'h01;
    ram[8'hFE] = 8'hAA; ram[8'hFF] = 8'hBB; ram[8'h00] = 8'hCC;
    ram[8'h30] = 8'h03; ram[8'h31] = 8'h09; ram[8'h32] = 8'h09; ram[8'h33] = 8'hF0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {mem_rd_en, mem_addr, out_data, out_valid, out_last, busy, done}, 0);
`ifdef RESULT_READER_ARGMAX_EN
    check("reset_argmax", {argmax_index, argmax_valid}, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic drain
    push_word(8'h05, 0); push_word(8'h7F, 0); push_word(8'h80, 0); push_word(8'h01, 1);
    for (int a = 8'h10; a <= 8'h13; a++) exp_addr.push_back(8'(a));
    drain(8'h10, 8'd4, 12, 8'd1, 1'b1);

    // Backpressure on word 2
    push_word(8'h05, 0); push_word(8'h7F, 0); push_word(8'h80, 0); push_word(8'h01, 1);
    for (int a = 8'h10; a <= 8'h13; a++) exp_addr.push_back(8'(a));
    stall_at = xfer_idx + 1;
    stall_left = 5;
    drain(8'h10, 8'd4, 17, 8'd1, 1'b1);
    check("stall_consumed", stall_left, 0);

    // Address wrap
    push_word(8'hAA, 0); push_word(8'hBB, 0); push_word(8'hCC, 1);
    exp_addr.push_back(8'hFE); exp_addr.push_back(8'hFF); exp_addr.push_back(8'h00);
    drain(8'hFE, 8'd3, 9, 8'd2, 1'b1);

    // Empty drain
    r0 = rd_cnt;
    v0 = valid_cnt;
    drain(8'h20, 8'd0, 0, 8'd0, 1'b0);
    check("empty_no_reads", rd_cnt, r0);
    check("empty_no_valid", valid_cnt, v0);

    // Argmax tie keeps lowest index
    push_word(8'h03, 0); push_word(8'h09, 0); push_word(8'h09, 0); push_word(8'hF0, 1);
    for (int a = 8'h30; a <= 8'h33; a++) exp_addr.push_back(8'(a));
    drain(8'h30, 8'd4, 12, 8'd1, 1'b1);

    // Start with another descriptor mid-drain is ignored
    push_word(8'h05, 0); push_word(8'h7F, 0); push_word(8'h80, 0); push_word(8'h01, 1);
    for (int a = 8'h10; a <= 8'h13; a++) exp_addr.push_back(8'(a));
    fork
      drain(8'h10, 8'd4, 12, 8'd1, 1'b1);
      begin
        repeat (5) @(posedge clk);
        #2;
        start = 1'b1;
        result_base_address = 8'h40;
        result_word_count = 8'd2;
        @(posedge clk);
        #2;
        start = 1'b0;
      end
    join
    r0 = rd_cnt;
    repeat (10) @(posedge clk);
    check("no_second_drain", rd_cnt, r0);

    // Reset during PRESENT of word 2
    push_word(8'h05, 0); push_word(8'h7F, 0); push_word(8'h80, 0); push_word(8'h01, 1);
    for (int a = 8'h10; a <= 8'h13; a++) exp_addr.push_back(8'(a));
    base_x = xfer_idx;
    issue_start(8'h10, 8'd4);
    k = 0;
    while (k < 100 && !(out_valid && xfer_idx == base_x + 1)) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("reach_word2", k < 100, 1);
    reset = 1'b1;
    exp_word.delete();
    exp_addr.delete();
    d0 = done_cnt;
    @(posedge clk);
    @(negedge clk);
    check("midreset_outputs", {mem_rd_en, mem_addr, out_data, out_valid, out_last, busy, done}, 0);
`ifdef RESULT_READER_ARGMAX_EN
    check("midreset_argmax", {argmax_index, argmax_valid}, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    check("no_done_after_reset", done_cnt, d0);

    // Full drain after reset
    push_word(8'h05, 0); push_word(8'h7F, 0); push_word(8'h80, 0); push_word(8'h01, 1);
    for (int a = 8'h10; a <= 8'h13; a++) exp_addr.push_back(8'(a));
    drain(8'h10, 8'd4, 12, 8'd1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/result_reader.md
# result_reader

Drain engine on the read side of the accelerator's result buffer. Once the `NeuralAccelerator` has finished, `result_reader` takes the result descriptor it reported (`result_base_address`, `result_word_count`). It reads that many words from the shared result RAM through a synchronous read port and streams them out over a valid/ready interface, flagging the last word. It is the consumer counterpart to the accelerator's result writer.

## Interface
- `DATA_WIDTH`, 8, result word width
- `ADDR_WIDTH`, 8, result RAM address width; also the width of the word count
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a drain; sampled only in IDLE
- `result_base_address`  in  ADDR_WIDTH  first word address; latched on accepted `start`
- `result_word_count`  in  ADDR_WIDTH  number of words; latched on accepted `start`
- `mem_rd_en`  out  1  RAM read strobe
- `mem_addr`  out  ADDR_WIDTH  RAM read address
- `mem_rd_data`  in  DATA_WIDTH  RAM data, valid the cycle after `mem_rd_en`
- `out_data`  out  DATA_WIDTH  streamed result word
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  downstream accepts the word
- `out_last`  out  1  the current word is the final one
- `busy`  out  1  a drain is in progress
- `done`  out  1  one-cycle completion pulse

## Operation
The block uses a state machine with states IDLE, READ, WAIT, PRESENT and DONE.

- **IDLE:** `start=1` latches the base address into `addr_q`, loads `remaining = count`, and clears the index. The next state is READ, or DONE if the count is 0.
- **READ:** drives `mem_rd_en=1` and `mem_addr=addr_q` for one cycle, then goes to WAIT.
- **WAIT:** captures `mem_rd_data` into `out_data` at the end of the cycle, then goes to PRESENT.
- **PRESENT:**
  - `out_valid=1`, and `out_data` stays stable until the word is transferred.
  - `out_last=1` when `remaining==1`.
  - A transfer (`out_valid & out_ready` at the edge) increments `addr_q` modulo 2^ADDR_WIDTH, decrements `remaining`, and increments the index.
  - After a transfer the next state is READ, or DONE if this was the last word.
- **DONE:** `done=1` for exactly one cycle, then the state returns to IDLE.

Behaviour details:
- `busy` is 1 in every state except IDLE, and still 1 during the DONE cycle.
- `start` is ignored outside IDLE, and descriptor inputs are ignored except on an accepted `start`.
- The address wraps: base 0xFE with count 3 reads 0xFE, 0xFF, 0x00.
- Count 0 issues no reads and produces no `out_valid`; `done` still pulses.
- `out_ready` asserted outside PRESENT has no effect.
- Reset during a drain forces IDLE and clears all outputs. No `done` pulse is produced, and the remaining words are discarded.

## Timing
- **Reset values:** `mem_rd_en`, `mem_addr`, `out_data`, `out_valid`, `out_last`, `busy` and `done` are all 0.
- **Start-up sequence:** `start` sampled at edge E0 gives READ in cycle E0+1, WAIT in E0+2, and PRESENT (`out_valid=1`) from E0+3.
- **Throughput:** 1 word per 3 cycles when `out_ready` is held at 1.
- **Completion:** the last transfer at edge En gives `done=1` in cycle En+1 and IDLE from En+2.
- **Back-to-back drains:** the earliest new `start` is accepted in the first IDLE cycle.
- **Registered outputs:** all outputs come straight from registers, with no combinational path from inputs to outputs.

## Configuration
- `RESULT_READER_ARGMAX_EN` defined adds two outputs:
  - `argmax_index` (ADDR_WIDTH): the word offset 0..count-1 of the maximum word.
  - `argmax_valid` (1): asserted together with `done` and held until the next accepted `start` or reset.
- Argmax rules:
  - Compares `out_data` as signed two's complement on each transfer.
  - On a tie, the lowest index is kept.
  - For count 0, `argmax_valid` stays 0.
  - On reset, both outputs are 0.
- Without the macro, the ports and all associated logic are absent and the stream behaviour is identical.

## Test plan
- **Basic drain:** RAM[0x10..0x13]=0x05,0x7F,0x80,0x01; start with base 0x10, count 4, `out_ready=1`.
  - Words stream as 05, 7F, 80, 01, with `out_last` only on 01.
  - `done` pulses 13 cycles after the start edge.
  - With argmax enabled: index 1, valid.
- **Backpressure:** as the basic drain, but `out_ready=0` for 5 cycles during word 2.
  - 7F is held stable with `out_valid=1`.
  - No duplicated or lost words.
- **Wrap:** base 0xFE, count 3.
  - `mem_addr` sequence is FE, FF, 00.
  - `out_last` is on the third word.
- **Empty drain:** count 0.
  - `mem_rd_en` never asserts and `out_valid` never asserts.
  - `done` pulses at E0+1; `argmax_valid` stays 0.
- **Ignored start and reset:** assert `start` with a different descriptor mid-drain; then assert `reset` during PRESENT of word 2.
  - The first drain is unaffected by the second `start`.
  - After reset, all outputs are 0 and no `done` pulse appears.
  - A new start after reset runs a full drain correctly.
- **Argmax tie:** with the macro, words 0x03, 0x09, 0x09, 0xF0.
  - `argmax_index` is 1.
